// File: rtl/ex_mul_div_unit.sv
// ex_mul_div_unit
//    EX-stage multiply/divide unit. Owns the architectural HI/LO registers and
//    runs MULT/MULTU/DIV/DIVU with a fixed latency set by a down-counter.
//    MTHI/MTLO write HI/LO directly in one cycle.
//
//    Ports
//       clk     in   system clock, rising edge
//       reset   in   asynchronous active-low reset
//       start   in   qualified MD instruction in EX (one-cycle pulse)
//       op      in   3-bit opcode: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//       srcA    in   rs operand (dividend / multiplicand / MTHI-MTLO data)
//       srcB    in   rt operand (divisor / multiplier)
//       cancel  in   flush of the EX instruction, suppresses start
//       busy    out  multi-cycle operation in progress
//       HI      out  HI register
//       LO      out  LO register
//
//    The result is computed combinationally at the accepting edge and parked in
//    a pending buffer; HI/LO only change when the counter reaches terminal count,
//    so the stage never observes a partial result.

module ex_mul_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   input  logic        cancel,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_wr_q, pend_wr_d;

   logic        op_valid;
   logic        accept;
   logic        signed_op;

   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] product;

   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic        div_zero;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] quot;
   logic [31:0] rem;

   assign busy = (cnt_q != 4'd0);
   assign HI   = hi_q;
   assign LO   = lo_q;

   assign op_valid  = (op != 3'd0) && (op != 3'd7);
   assign accept    = start & ~cancel & ~busy & op_valid;
   assign signed_op = (op == OP_MULT) || (op == OP_DIV);

   // Sign- or zero-extend to 64 bits; the low 64 bits of the 64x64 product are
   // the correct signed or unsigned 32x32 result.
   assign mul_a   = {{32{signed_op & srcA[31]}}, srcA};
   assign mul_b   = {{32{signed_op & srcB[31]}}, srcB};
   assign product = mul_a * mul_b;

   // Signed divide via magnitudes. 0x80000000 negates to itself, which is also
   // its correct unsigned magnitude, so the overflow case falls out naturally:
   // 0x80000000 / 1 = 0x80000000, negated back to 0x80000000, remainder 0.
   assign a_neg    = signed_op & srcA[31];
   assign b_neg    = signed_op & srcB[31];
   assign a_mag    = a_neg ? (~srcA + 32'd1) : srcA;
   assign b_mag    = b_neg ? (~srcB + 32'd1) : srcB;
   assign div_zero = (srcB == 32'd0);
   assign uq       = div_zero ? 32'd0 : (a_mag / b_mag);
   assign ur       = div_zero ? 32'd0 : (a_mag % b_mag);
   assign quot     = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
   assign rem      = a_neg ? (~ur + 32'd1) : ur;

   always_comb begin
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;

      // Terminal count: commit on the 1 -> 0 transition.
      if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
         if ((cnt_q == 4'd1) && pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
      end

      // accept implies the counter is idle, so this never collides with a commit.
      if (accept) begin
         case (op)
            OP_MULT, OP_MULTU: begin
               pend_hi_d = product[63:32];
               pend_lo_d = product[31:0];
               pend_wr_d = 1'b1;
               cnt_d     = MULT_LOAD;
            end
            OP_DIV, OP_DIVU: begin
               pend_hi_d = rem;
               pend_lo_d = quot;
               // Divide by zero runs full length but leaves HI/LO untouched.
               pend_wr_d = ~div_zero;
               cnt_d     = DIV_LOAD;
            end
            OP_MTHI: hi_d = srcA;
            OP_MTLO: lo_d = srcA;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= 4'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

endmodule

// File: tb/tb_ex_mul_div_unit.sv
// tb_ex_mul_div_unit
//    Table of {op, operands, expected HI/LO, busy length} records applied in a
//    loop, followed by hand-written multi-cycle sequences. Expected HI/LO are
//    pushed to a scoreboard queue at issue and popped when busy drops.

module tb_ex_mul_div_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        cancel;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   ex_mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .srcA   (srcA),
      .srcB   (srcB),
      .cancel (cancel),
      .busy   (busy),
      .HI     (HI),
      .LO     (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   vec_t        vecs[16];
   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_hi;
   logic [31:0] model_lo;

   function automatic vec_t mk(logic [2:0] o, logic [31:0] a, logic [31:0] b,
                               logic [31:0] h, logic [31:0] l, int c);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.hi = h; v.lo = l; v.cyc = c;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns just after the accepting posedge.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
      exp_t e;
      e.hi = eh; e.lo = el;
      sb.push_back(e);
      start = 1'b1; op = o; srcA = a; srcB = b;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd0;
   endtask

   // Counts busy cycles at negedges, checks HI/LO hold during busy, then
   // compares the committed value against the scoreboard. Returns at a negedge
   // with busy low.
   task automatic wait_done(input string name, input int exp_cyc);
      int   n;
      logic hold;
      exp_t e;
      n = 0;
      hold = 1'b1;
      @(negedge clk);
      while (busy && n < 40) begin
         if (HI !== model_hi || LO !== model_lo) hold = 1'b0;
         n++;
         @(negedge clk);
      end
      if (n >= 40) begin
         errors++;
         checks++;
         $display("FAIL %s timeout: busy still high after %0d cycles", name, n);
      end
      chk({name, " busy_cycles"}, 64'(n), 64'(exp_cyc));
      chk({name, " hold"}, {63'd0, hold}, 64'd1);
      if (sb.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         chk({name, " HI"}, {32'd0, HI}, {32'd0, e.hi});
         chk({name, " LO"}, {32'd0, LO}, {32'd0, e.lo});
         model_hi = e.hi;
         model_lo = e.lo;
      end
   endtask

   initial begin
      vecs[0]  = mk(3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      vecs[1]  = mk(3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5);
      vecs[2]  = mk(3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      vecs[3]  = mk(3'd4, 32'd7,        32'd2,        32'd1,        32'd3,        10);
      vecs[4]  = mk(3'd5, 32'h11,       32'd0,        32'h11,       32'd3,        0);
      vecs[5]  = mk(3'd6, 32'h22,       32'd0,        32'h11,       32'h22,       0);
      vecs[6]  = mk(3'd3, 32'd5,        32'd0,        32'h11,       32'h22,       10);
      vecs[7]  = mk(3'd4, 32'd5,        32'd0,        32'h11,       32'h22,       10);
      vecs[8]  = mk(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10);
      vecs[9]  = mk(3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10);
      vecs[10] = mk(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        5);
      vecs[11] = mk(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
      vecs[12] = mk(3'd4, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 10);
      vecs[13] = mk(3'd0, 32'd1,        32'd2,        32'hF,        32'h0FFFFFFF, 0);
      vecs[14] = mk(3'd7, 32'd1,        32'd2,        32'hF,        32'h0FFFFFFF, 0);
      vecs[15] = mk(3'd3, 32'h80000000, 32'd3,        32'hFFFFFFFE, 32'hD5555556, 10);

      start = 1'b0; op = 3'd0; srcA = '0; srcB = '0; cancel = 1'b0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset HI", {32'd0, HI}, 64'd0);
      chk("reset LO", {32'd0, LO}, 64'd0);
      model_hi = 32'd0;
      model_lo = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
         wait_done($sformatf("vec%0d", i), vecs[i].cyc);
      end

      // MTHI while busy is ignored and does not disturb the running MULT.
      issue(3'd1, 32'd2, 32'd3, 32'd0, 32'd6);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; op = 3'd5; srcA = 32'hDEAD;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd0;
      chk("mthi_busy HI", {32'd0, HI}, {32'd0, model_hi});
      wait_done("mthi_busy", 3);

      // start with cancel is dropped.
      start = 1'b1; op = 3'd1; srcA = 32'd9; srcB = 32'd9; cancel = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd0; cancel = 1'b0;
      @(negedge clk);
      chk("cancel busy", {63'd0, busy}, 64'd0);
      chk("cancel HI", {32'd0, HI}, {32'd0, model_hi});
      chk("cancel LO", {32'd0, LO}, {32'd0, model_lo});

      // cancel while busy does not abort the older operation.
      issue(3'd4, 32'd100, 32'd7, 32'd2, 32'd14);
      @(negedge clk);
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      wait_done("cancel_busy", 9);

      // Back-to-back: each issue happens on the first negedge with busy low.
      issue(3'd4, 32'd7, 32'd2, 32'd1, 32'd3);
      wait_done("b2b divu", 10);
      issue(3'd6, 32'h1234, 32'd0, 32'd1, 32'h1234);
      wait_done("b2b mtlo", 0);
      issue(3'd1, 32'd2, 32'd3, 32'd0, 32'd6);
      wait_done("b2b mult", 5);
      issue(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      wait_done("b2b div", 10);
      issue(3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
      wait_done("b2b mult2", 5);

      // Async reset mid-DIV aborts it with no later commit.
      issue(3'd4, 32'd7, 32'd2, 32'd1, 32'd3);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midreset busy", {63'd0, busy}, 64'd0);
      chk("midreset HI", {32'd0, HI}, 64'd0);
      chk("midreset LO", {32'd0, LO}, 64'd0);
      if (sb.size() != 0) void'(sb.pop_front());
      model_hi = 32'd0;
      model_lo = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      repeat (15) @(negedge clk);
      chk("postreset busy", {63'd0, busy}, 64'd0);
      chk("postreset HI", {32'd0, HI}, 64'd0);
      chk("postreset LO", {32'd0, LO}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
